// File: rtl/calc_opcode_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : calc_opcode_encoder_pkg
// Purpose  : Shared definitions for the calculator control path: the 3-bit
//            opcode values seen by the calculator FSM, the encoder state
//            encodings, button index map and the press priority encoder.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package calc_opcode_encoder_pkg;

  // Opcodes driven to the calculator FSM. 3'b011 is never produced.
  localparam logic [2:0] OP_CLEAR = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_ENTER = 3'b010;
  localparam logic [2:0] OP_OP0   = 3'b100;
  localparam logic [2:0] OP_OP1   = 3'b101;
  localparam logic [2:0] OP_OP2   = 3'b110;
  localparam logic [2:0] OP_IDLE  = 3'b111;

  // Encoder FSM states.
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_HOLD     = 2'd1;
  localparam logic [1:0] S_WAIT_REL = 2'd2;

  // Bit positions of each button in the packed button vectors.
  localparam int NUM_BTN   = 6;
  localparam int BTN_CLEAR = 0;
  localparam int BTN_LOAD  = 1;
  localparam int BTN_ENTER = 2;
  localparam int BTN_OP0   = 3;
  localparam int BTN_OP1   = 4;
  localparam int BTN_OP2   = 5;

  // Priority: clear > enter > load > op2 > op1 > op0.
  function automatic logic [2:0] encode_press(input logic [NUM_BTN-1:0] i_press);
    logic [2:0] w_op;
    if (i_press[BTN_CLEAR])      w_op = OP_CLEAR;
    else if (i_press[BTN_ENTER]) w_op = OP_ENTER;
    else if (i_press[BTN_LOAD])  w_op = OP_LOAD;
    else if (i_press[BTN_OP2])   w_op = OP_OP2;
    else if (i_press[BTN_OP1])   w_op = OP_OP1;
    else if (i_press[BTN_OP0])   w_op = OP_OP0;
    else                         w_op = OP_IDLE;
    return w_op;
  endfunction

endpackage : calc_opcode_encoder_pkg
`default_nettype wire

// File: rtl/calc_opcode_encoder_debounce.sv
`default_nettype none
// ============================================================================
// Module   : calc_opcode_encoder_debounce
// Purpose  : One push-button front end: 2-flop synchroniser, counting
//            debouncer and registered one-cycle press pulse.
// Ports    : clk      - system clock, rising edge
//            reset    - synchronous, active-high reset
//            i_btn    - raw asynchronous button level
//            o_level  - debounced level
//            o_press  - one-cycle pulse, registered one clock after the
//                       debounced level rises
// Revision : 1.0 - initial release
// ============================================================================
module calc_opcode_encoder_debounce #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_level,
  output logic o_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_level_d;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      // Rising edge of the debounced level, registered so every output
      // downstream stays registered.
      r_press   <= r_level & ~r_level_d;
      // Any sample agreeing with the current level restarts the count, so
      // only an unbroken run of DEBOUNCE_CYCLES disagreeing samples flips it.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_last) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule : calc_opcode_encoder_debounce
`default_nettype wire

// File: rtl/calc_opcode_encoder.sv
`default_nettype none
// ============================================================================
// Module   : calc_opcode_encoder
// Purpose  : Turns raw calculator push-buttons into the 3-bit opcode stream
//            for the calculator FSM. Each button is debounced; presses are
//            priority-encoded and the opcode is held for HOLD_CYCLES clocks,
//            after which the block waits for all buttons to be released.
// Ports    : clk          - system clock, rising edge
//            reset        - synchronous, active-high reset
//            btn_clear    - raw clear button
//            btn_load     - raw load button
//            btn_enter    - raw enter button
//            btn_op[2:0]  - raw operator buttons
//            opcode_out   - opcode to FSM, OP_IDLE when no command
//            opcode_valid - high exactly while opcode_out != OP_IDLE
//            busy         - high while holding or waiting for release
// Revision : 1.0 - initial release
// ============================================================================
module calc_opcode_encoder
  import calc_opcode_encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int HOLD_CYCLES     = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_clear,
  input  logic       btn_load,
  input  logic       btn_enter,
  input  logic [2:0] btn_op,
  output logic [2:0] opcode_out,
  output logic       opcode_valid,
  output logic       busy
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(HOLD_CYCLES - 1);

  logic [NUM_BTN-1:0] w_raw;
  logic [NUM_BTN-1:0] w_level;
  logic [NUM_BTN-1:0] w_press;

  logic [1:0]        r_state;
  logic [2:0]        r_opcode;
  logic              r_valid;
  logic              r_busy;
  logic [HOLD_W-1:0] r_hold_cnt;

  logic [1:0]        w_state_nxt;
  logic [2:0]        w_opcode_nxt;
  logic [HOLD_W-1:0] w_cnt_nxt;

  assign w_raw = {btn_op, btn_enter, btn_load, btn_clear};

  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      calc_opcode_encoder_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk    (clk),
        .reset  (reset),
        .i_btn  (w_raw[gi]),
        .o_level(w_level[gi]),
        .o_press(w_press[gi])
      );
    end
  endgenerate

  always_comb begin
    w_state_nxt  = r_state;
    w_opcode_nxt = r_opcode;
    w_cnt_nxt    = r_hold_cnt;
    case (r_state)
      S_IDLE: begin
        if (|w_press) begin
          w_state_nxt  = S_HOLD;
          w_opcode_nxt = encode_press(w_press);
          w_cnt_nxt    = '0;
        end
      end
      S_HOLD: begin
        // Clear restarts the hold, but a clear already on the bus runs out.
        if (w_press[BTN_CLEAR] && (r_opcode != OP_CLEAR)) begin
          w_opcode_nxt = OP_CLEAR;
          w_cnt_nxt    = '0;
        end else if (r_hold_cnt == c_hold_last) begin
          w_state_nxt  = S_WAIT_REL;
          w_opcode_nxt = OP_IDLE;
        end else begin
          w_cnt_nxt = r_hold_cnt + HOLD_W'(1);
        end
      end
      S_WAIT_REL: begin
        if (w_press[BTN_CLEAR]) begin
          w_state_nxt  = S_HOLD;
          w_opcode_nxt = OP_CLEAR;
          w_cnt_nxt    = '0;
        end else if (w_level == '0) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_opcode_nxt = OP_IDLE;
        w_cnt_nxt    = '0;
      end
    endcase
  end

  // Flags are derived from the next opcode/state so they always line up
  // with the registered opcode.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_opcode   <= OP_IDLE;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_opcode   <= w_opcode_nxt;
      r_valid    <= (w_opcode_nxt != OP_IDLE);
      r_busy     <= (w_state_nxt != S_IDLE);
      r_hold_cnt <= w_cnt_nxt;
    end
  end

  assign opcode_out   = r_opcode;
  assign opcode_valid = r_valid;
  assign busy         = r_busy;

endmodule : calc_opcode_encoder
`default_nettype wire
